// File: rtl/OoO_pkg.sv
`default_nettype none
// ============================================================================
// Module   : OoO_pkg
// Purpose  : Shared response record and address helper for the OBI memory.
// Revision : 1.0  initial release
// ============================================================================
package OoO_pkg;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } obi_resp_t;

    // Offset is computed modulo 2^32, so the lower bound must be tested on addr itself.
    function automatic logic addr_in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [32:0] span
    );
        logic [31:0] offset;
        offset = addr - base;
        return (addr >= base) && ({1'b0, offset} < span);
    endfunction

endpackage
`default_nettype wire

// File: rtl/obi_resp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : obi_resp_pipe
// Purpose  : Fixed-depth delay line for OBI responses; no backpressure.
// Revision : 1.0  initial release
// ============================================================================
module obi_resp_pipe
    import OoO_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic      clock,
    input  logic      reset,
    input  obi_resp_t i_resp,
    output obi_resp_t o_resp
);

    obi_resp_t r_stage [LATENCY];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_resp;
            for (int i = 1; i < LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_resp = r_stage[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : obi_mem_responder
// Purpose  : OBI memory target with fixed response latency and bounded outstanding.
// Revision : 1.0  initial release
// ============================================================================
module obi_mem_responder
    import OoO_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned MAX_OUTST   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned c_idx_w = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned c_cnt_w = $clog2(MAX_OUTST + 1);
    localparam logic [c_cnt_w-1:0] c_max_outst = c_cnt_w'(MAX_OUTST);
    localparam logic [32:0] c_span = 33'(DEPTH_WORDS) << 2;

    logic [31:0]        r_mem [DEPTH_WORDS];
    logic [c_cnt_w-1:0] r_outst_cnt;

    logic [31:0]        w_offset;
    logic [c_idx_w-1:0] w_idx;
    logic               w_in_range;
    logic               w_retire;
    logic               w_gnt;
    obi_resp_t          w_resp_in;
    obi_resp_t          w_resp_out;

    assign w_offset   = addr_i - BASE_ADDR;
    assign w_idx      = w_offset[c_idx_w+1:2];
    assign w_in_range = addr_in_range(addr_i, BASE_ADDR, c_span);
    assign w_retire   = w_resp_out.valid;

    // A retiring response frees its slot in the same cycle, which keeps a full pipe streaming.
    assign w_gnt = ~reset & req_i & ~stall_i & ((r_outst_cnt < c_max_outst) | w_retire);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_outst_cnt <= '0;
        end else if (w_gnt && !w_retire) begin
            r_outst_cnt <= r_outst_cnt + 1'b1;
        end else if (!w_gnt && w_retire) begin
            r_outst_cnt <= r_outst_cnt - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_gnt && we_i && w_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        w_resp_in       = '0;
        w_resp_in.valid = w_gnt;
        w_resp_in.err   = w_gnt & ~w_in_range;
        if (w_gnt && !we_i && w_in_range) begin
            w_resp_in.rdata = r_mem[w_idx];
        end
    end

    obi_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_resp_pipe (
        .clock  (clock),
        .reset  (reset),
        .i_resp (w_resp_in),
        .o_resp (w_resp_out)
    );

    assign gnt_o    = w_gnt;
    assign rvalid_o = w_resp_out.valid;
    assign err_o    = w_resp_out.err;
    assign rdata_o  = w_resp_out.rdata;

endmodule
`default_nettype wire

// File: tb/tb_obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_obi_mem_responder
// Purpose  : Directed vector bench for obi_mem_responder (LATENCY=2).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_obi_mem_responder;

    localparam int unsigned c_lat = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall, req, req2, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        gnt, rvalid, err, gnt2, rvalid2, err2;
    logic [31:0] rdata, rdata2;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    obi_mem_responder dut (
        .clock(clock), .reset(reset), .stall_i(stall), .req_i(req),
        .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err)
    );

    obi_mem_responder #(.MAX_OUTST(1)) dut2 (
        .clock(clock), .reset(reset), .stall_i(stall), .req_i(req2),
        .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
        .gnt_o(gnt2), .rvalid_o(rvalid2), .rdata_o(rdata2), .err_o(err2)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [3:0] b,
                                input logic [31:0] d, input logic e, input logic [31:0] r);
        vec_t v;
        v.we = w; v.addr = a; v.be = b; v.wdata = d; v.exp_err = e; v.exp_rdata = r;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        we = v.we; addr = v.addr; be = v.be; wdata = v.wdata;
    endtask

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic run_txn(input vec_t v, input int idx);
        int waited;
        int lat;
        drive(v);
        req = 1'b1;
        waited = 0;
        @(negedge clock);
        while (!gnt && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        check("gnt_wait", idx, gnt, 1'b1);
        if (!gnt) begin
            req = 1'b0;
            @(posedge clock); #1;
            return;
        end
        @(posedge clock); #1;
        req = 1'b0;
        lat = 0;
        while (!rvalid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        check("latency", idx, lat, c_lat - 1);
        check("err", idx, err, v.exp_err);
        check("rdata", idx, rdata, v.exp_rdata);
        @(posedge clock); #1;
        check("rvalid_single", idx, rvalid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        b2b [4];
        logic [31:0] m1_addr [3];
        logic        m1_err [3];
        int          gcount, ri, rv_seen;
        logic        g;

        vecs[0]  = mk(1'b1, 32'h8000_0000, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0);
        vecs[1]  = mk(1'b0, 32'h8000_0000, 4'h0, 32'h0,         1'b0, 32'hDEAD_BEEF);
        vecs[2]  = mk(1'b1, 32'h8000_0010, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0);
        vecs[3]  = mk(1'b1, 32'h8000_0010, 4'h5, 32'h1122_3344, 1'b0, 32'h0);
        vecs[4]  = mk(1'b0, 32'h8000_0010, 4'h0, 32'h0,         1'b0, 32'hFF22_FF44);
        vecs[5]  = mk(1'b0, 32'h8000_0013, 4'h0, 32'h0,         1'b0, 32'hFF22_FF44);
        vecs[6]  = mk(1'b1, 32'h8000_0010, 4'h0, 32'h0,         1'b0, 32'h0);
        vecs[7]  = mk(1'b0, 32'h8000_0010, 4'h0, 32'h0,         1'b0, 32'hFF22_FF44);
        vecs[8]  = mk(1'b1, 32'h8000_0FFC, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0);
        vecs[9]  = mk(1'b0, 32'h8000_0FFC, 4'h0, 32'h0,         1'b0, 32'hCAFE_F00D);
        vecs[10] = mk(1'b0, 32'h7FFF_FFFC, 4'h0, 32'h0,         1'b1, 32'h0);
        vecs[11] = mk(1'b1, 32'h8000_1000, 4'hF, 32'h1234_5678, 1'b1, 32'h0);
        vecs[12] = mk(1'b0, 32'h8000_0000, 4'h0, 32'h0,         1'b0, 32'hDEAD_BEEF);
        vecs[13] = mk(1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0,         1'b1, 32'h0);

        b2b[0] = mk(1'b1, 32'h8000_0020, 4'hF, 32'hA5A5_A5A5, 1'b0, 32'h0);
        b2b[1] = mk(1'b0, 32'h8000_0020, 4'h0, 32'h0,         1'b0, 32'hA5A5_A5A5);
        b2b[2] = mk(1'b1, 32'h8000_0024, 4'hF, 32'h0102_0304, 1'b0, 32'h0);
        b2b[3] = mk(1'b0, 32'h8000_0024, 4'h0, 32'h0,         1'b0, 32'h0102_0304);

        m1_addr[0] = 32'h8000_0000; m1_err[0] = 1'b0;
        m1_addr[1] = 32'h7FFF_FFFC; m1_err[1] = 1'b1;
        m1_addr[2] = 32'h8000_0004; m1_err[2] = 1'b0;

        reset = 1'b1; stall = 1'b0; req = 1'b1; req2 = 1'b1;
        we = 1'b0; addr = 32'h8000_0000; be = 4'h0; wdata = 32'h0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_gnt", 0, gnt, 1'b0);
        check("rst_gnt2", 0, gnt2, 1'b0);
        check("rst_rvalid", 0, rvalid, 1'b0);
        check("rst_rdata", 0, rdata, 32'h0);
        check("rst_err", 0, err, 1'b0);
        check("rst_outst", 0, dut.r_outst_cnt, 0);
        @(posedge clock); #1;
        req = 1'b0; req2 = 1'b0; reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 14; i++) begin
            run_txn(vecs[i], i);
        end

        // Back-to-back: write then read of the same word on consecutive grants.
        drive(b2b[0]);
        req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (c < 4) check("b2b_gnt", c, gnt, 1'b1);
            @(posedge clock); #1;
            if (c >= 1) begin
                check("b2b_rvalid", c, rvalid, 1'b1);
                check("b2b_rdata", c, rdata, b2b[c-1].exp_rdata);
                check("b2b_err", c, err, 1'b0);
            end
            if (c < 3) drive(b2b[c+1]);
            else req = 1'b0;
        end
        @(posedge clock); #1;
        check("b2b_drain", 0, rvalid, 1'b0);

        // Stall inhibits grant; grant follows as soon as stall drops.
        drive(vecs[1]);
        stall = 1'b1; req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("stall_gnt", c, gnt, 1'b0);
            @(posedge clock); #1;
        end
        stall = 1'b0;
        @(negedge clock);
        check("stall_release_gnt", 0, gnt, 1'b1);
        @(posedge clock); #1;
        req = 1'b0;
        @(posedge clock); #1;
        check("stall_rvalid", 0, rvalid, 1'b1);
        check("stall_rdata", 0, rdata, 32'hDEAD_BEEF);
        @(posedge clock); #1;

        // MAX_OUTST=1: alternate-cycle grants with in-order responses.
        we = 1'b0; be = 4'h0; wdata = 32'h0; addr = m1_addr[0];
        req2 = 1'b1; gcount = 0; ri = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            check("max1_gnt", c, gnt2, (c < 6) && (c % 2 == 0));
            g = gnt2;
            @(posedge clock); #1;
            if (rvalid2) begin
                if (ri < 3) begin
                    check("max1_err", ri, err2, m1_err[ri]);
                    if (m1_err[ri]) check("max1_rdata", ri, rdata2, 32'h0);
                end
                ri++;
            end
            if (g) begin
                gcount++;
                if (gcount < 3) addr = m1_addr[gcount];
            end
            if (c == 5) req2 = 1'b0;
        end
        check("max1_grants", 0, gcount, 3);
        check("max1_responses", 0, ri, 3);

        // Reset during flight discards the pending response.
        drive(vecs[1]);
        req = 1'b1;
        @(negedge clock);
        check("rstmid_gnt", 0, gnt, 1'b1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("rstmid_gnt_held", 0, gnt, 1'b0);
        check("rstmid_outst", 0, dut.r_outst_cnt, 0);
        @(posedge clock); #1;
        req = 1'b0; reset = 1'b0;
        rv_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock); #1;
            if (rvalid) rv_seen++;
        end
        check("rstmid_no_rvalid", 0, rv_seen, 0);
        check("rstmid_outst_after", 0, dut.r_outst_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/obi_mem_responder.md
OBI_MEM_RESPONDER -- requirements
Module: obi_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: memory size in 32-bit words, power of two.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h8000_0000: byte address of word 0.
REQ-003 SHALL have parameter LATENCY, default 2, legal range 1..8: cycles from grant to rvalid.
REQ-004 SHALL have parameter MAX_OUTST, default 2, legal range 1..LATENCY: maximum granted-but-unanswered requests.
REQ-005 SHALL have port clock, input, 1: sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port stall_i, input, 1: bench-driven grant inhibit.
REQ-008 SHALL have port req_i, input, 1: initiator request.
REQ-009 SHALL have port addr_i, input, 32: byte address.
REQ-010 SHALL have port we_i, input, 1: 1 = write, 0 = read.
REQ-011 SHALL have port be_i, input, 4: write byte enables.
REQ-012 SHALL have port wdata_i, input, 32: write data.
REQ-013 SHALL have port gnt_o, output, 1: request accepted this cycle.
REQ-014 SHALL have port rvalid_o, output, 1: response valid, one cycle per granted request.
REQ-015 SHALL have port rdata_o, output, 32: read data.
REQ-016 SHALL have port err_o, output, 1: address-range error, qualified by rvalid_o.

Function
REQ-017 gnt_o SHALL be combinational: req_i & ~stall_i & (outst_cnt < MAX_OUTST | retiring this cycle).
REQ-018 A request SHALL be accepted exactly on the rising edge where req_i & gnt_o = 1; the initiator holds addr/we/be/wdata stable until then.
REQ-019 Word index SHALL be (addr_i - BASE_ADDR) >> 2; addr_i[1:0] SHALL be ignored.
REQ-020 In range: BASE_ADDR <= addr_i < BASE_ADDR + 4*DEPTH_WORDS. Out of range: no memory access, response err_o=1, rdata_o=0.
REQ-021 A write SHALL update only the bytes with be_i set, at the grant edge; be_i=0 SHALL still produce a response.
REQ-022 A read SHALL sample memory at the grant edge; a read granted the cycle after a write to the same word SHALL return the new data.
REQ-023 The response for a request granted at edge N SHALL appear with rvalid_o=1 in the cycle following edge N+LATENCY-1 (LATENCY=1: the cycle after grant).
REQ-024 Responses SHALL be in grant order; the pipeline SHALL carry {valid, err, rdata} per stage, with no backpressure on the response side.
REQ-025 A write response SHALL have rdata_o=0 and err_o per REQ-020.
REQ-026 When rvalid_o=0, rdata_o and err_o SHALL be 0.
REQ-027 outst_cnt SHALL increment on grant only, decrement on rvalid_o only, and stay unchanged when both occur in the same cycle; it never exceeds MAX_OUTST.
REQ-028 Back-to-back grants every cycle SHALL be sustained when MAX_OUTST >= LATENCY.

Reset
REQ-029 While reset=1: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, outst_cnt=0, all pipeline valid bits 0.
REQ-030 Reset asserted mid-operation SHALL discard in-flight responses; no rvalid_o SHALL be produced for them after release.
REQ-031 Memory contents SHALL NOT be reset; bench preloads them via hierarchical access or $readmemh.

Structure
REQ-032 Typedef obi_resp_t {logic valid; logic err; logic [31:0] rdata;} SHALL be placed in OoO_pkg.
REQ-033 The LATENCY-deep response delay line SHALL be a sub-module obi_resp_pipe (parameter LATENCY, type obi_resp_t).
REQ-034 Memory SHALL be a plain unpacked word array inferred as synchronous-write storage; there SHALL be no other sub-modules.

Verification
REQ-035 Preload word 0 = 32'hDEAD_BEEF, LATENCY=2. Read 32'h8000_0000 granted at edge 0 -> rvalid_o=1, rdata_o=32'hDEAD_BEEF after edge 1, err_o=0.
REQ-036 Write 32'h1122_3344 to 32'h8000_0010 with be=4'b0101 over 32'hFFFF_FFFF, then read the same address -> 32'hFF22_FF44.
REQ-037 With MAX_OUTST=1, LATENCY=2 and req_i held high for 6 cycles -> gnt_o on alternate cycles, 3 grants, 3 in-order responses.
REQ-038 Read 32'h7FFF_FFFC, then write to 32'h8000_1000 (DEPTH 1024) -> both responses have err_o=1 and rdata_o=0; memory is unchanged.
REQ-039 Assert stall_i for 3 cycles with req_i high -> gnt_o=0 throughout; grant follows in the first cycle after stall_i drops.
REQ-040 Assert reset one cycle after a grant -> rvalid_o stays 0 for 10 cycles after release; outst_cnt=0.
